// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : Memory stage of the 5-stage MIPS pipeline. Drives data-memory
//            loads/stores over the dcache request/ack handshake, resolves
//            branch and jump PC redirects, owns the MEM/WB pipeline register
//            and raises the memory-stall request for the hazard unit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WAIT_LIMIT : consecutive WAIT cycles before mem_timeout sets (0 = off)
//   JAL_REG    : destination register written by jal
// Build options
//   MEM_PERF_CNT_EN : when defined, perf_stall_cnt / perf_mem_ops count
//                     memory stall cycles and accepted dcache acks; when
//                     undefined both outputs are tied to zero.
// Ports
//   CLK, nRST                 clock (rising edge), synchronous active-low reset
//   ex_*                      EX/MEM register contents for this instruction
//   ext_stall                 non-memory freeze from the hazard unit
//   dhit, dmemload            dcache ack and load data
//   dmemREN/WEN/addr/store    dcache request
//   mem_stall                 request outstanding without ack
//   pc_redirect, pc_target    taken branch / jump this cycle
//   wb_regWrite/wsel/wdat     MEM/WB register outputs
//   wb_halt                   sticky halt
//   mem_timeout               sticky wait-limit violation
//   perf_stall_cnt/mem_ops    optional performance counters
// ============================================================================
module mem_wb_stage #(
   parameter int unsigned WAIT_LIMIT = 0,
   parameter logic [4:0]  JAL_REG    = 5'd31
) (
   input  logic        CLK,
   input  logic        nRST,
   // EX/MEM register contents
   input  logic [31:0] ex_cpc,
   input  logic        ex_regWrite,
   input  logic        ex_memtoReg,
   input  logic        ex_halt,
   input  logic        ex_branch,
   input  logic        ex_zflag,
   input  logic        ex_dren,
   input  logic        ex_dwen,
   input  logic [1:0]  ex_jump,
   input  logic [31:0] ex_aluout,
   input  logic [31:0] ex_writeData,
   input  logic [31:0] ex_imm,
   input  logic [4:0]  ex_wsel,
   input  logic [25:0] ex_jaddr,
   // hazard unit
   input  logic        ext_stall,
   // dcache
   input  logic        dhit,
   input  logic [31:0] dmemload,
   output logic        dmemREN,
   output logic        dmemWEN,
   output logic [31:0] dmemaddr,
   output logic [31:0] dmemstore,
   // pipeline control
   output logic        mem_stall,
   output logic        pc_redirect,
   output logic [31:0] pc_target,
   // MEM/WB register
   output logic        wb_regWrite,
   output logic [4:0]  wb_wsel,
   output logic [31:0] wb_wdat,
   output logic        wb_halt,
   // status / performance
   output logic        mem_timeout,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_mem_ops
);

   // ------------------------------------------------------------------------
   // Encodings
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no request outstanding
      ST_WAIT = 2'd1,   // request issued, waiting for dhit
      ST_DONE = 2'd2    // data acked while frozen; result parked in hold_q
   } state_t;

   localparam logic [1:0] JMP_NONE = 2'b00;
   localparam logic [1:0] JMP_J    = 2'b01;
   localparam logic [1:0] JMP_JR   = 2'b10;
   localparam logic [1:0] JMP_JAL  = 2'b11;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t      state_q,       state_d;
   logic [31:0] hold_q,        hold_d;
   logic        wb_regWrite_q, wb_regWrite_d;
   logic [4:0]  wb_wsel_q,     wb_wsel_d;
   logic [31:0] wb_wdat_q,     wb_wdat_d;
   logic        wb_halt_q,     wb_halt_d;

   // ------------------------------------------------------------------------
   // Request / stall qualification
   // ------------------------------------------------------------------------
   logic w_req;      // instruction wants the data memory
   logic w_active;   // FSM may present a request (not parked in DONE)
   logic w_stall;    // request outstanding and not yet acked
   logic w_adv;      // MEM/WB may accept this instruction
   logic w_is_jal;

   // A halted core must never touch memory again, so halt gates the request.
   assign w_req    = (ex_dren | ex_dwen) & ~wb_halt_q;
   assign w_active = (state_q != ST_DONE);
   assign w_stall  = w_req & ~dhit & w_active;
   assign w_adv    = ~w_stall & ~ext_stall;
   assign w_is_jal = (ex_jump == JMP_JAL);

   // Store takes priority when both enables are set.
   assign dmemWEN   = ex_dwen & w_req & w_active;
   assign dmemREN   = ex_dren & ~ex_dwen & w_req & w_active;
   assign dmemaddr  = ex_aluout;
   assign dmemstore = ex_writeData;
   assign mem_stall = w_stall;

   // ------------------------------------------------------------------------
   // Memory handshake FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // An ack that arrives while the hazard unit freezes us cannot be written
   // back yet, and dmemload is not guaranteed to stay valid; park it in
   // hold_q and stop requesting until the freeze lifts.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (w_req) begin
               if (!dhit) begin
                  state_d = ST_WAIT;
               end else if (ext_stall) begin
                  state_d = ST_DONE;
                  hold_d  = dmemload;
               end
            end
         end
         ST_WAIT: begin
            if (dhit) begin
               if (ext_stall) begin
                  state_d = ST_DONE;
                  hold_d  = dmemload;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DONE: begin
            if (!ext_stall) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // PC redirect
   // ------------------------------------------------------------------------
   // Only an instruction actually leaving the stage may steer fetch; a
   // stalled one would otherwise redirect repeatedly.
   always_comb begin
      pc_redirect = 1'b0;
      pc_target   = '0;
      if (w_adv && !wb_halt_q) begin
         case (ex_jump)
            JMP_J, JMP_JAL: begin
               pc_redirect = 1'b1;
               pc_target   = {ex_cpc[31:28], ex_jaddr, 2'b00};
            end
            JMP_JR: begin
               pc_redirect = 1'b1;
               pc_target   = ex_aluout;
            end
            default: begin
               if (ex_branch && ex_zflag) begin
                  pc_redirect = 1'b1;
                  pc_target   = ex_cpc + (ex_imm << 2);
               end
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // MEM/WB pipeline register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         wb_regWrite_q <= 1'b0;
         wb_wsel_q     <= '0;
         wb_wdat_q     <= '0;
         wb_halt_q     <= 1'b0;
      end else begin
         wb_regWrite_q <= wb_regWrite_d;
         wb_wsel_q     <= wb_wsel_d;
         wb_wdat_q     <= wb_wdat_d;
         wb_halt_q     <= wb_halt_d;
      end
   end

   always_comb begin
      wb_regWrite_d = wb_regWrite_q;
      wb_wsel_d     = wb_wsel_q;
      wb_wdat_d     = wb_wdat_q;
      wb_halt_d     = wb_halt_q;
      if (w_adv) begin
         wb_regWrite_d = (ex_regWrite | w_is_jal) & ~wb_halt_q;
         wb_wsel_d     = w_is_jal ? JAL_REG : ex_wsel;
         if (w_is_jal) begin
            wb_wdat_d = ex_cpc;
         end else if (ex_memtoReg) begin
            // In DONE the live bus may already carry unrelated data.
            wb_wdat_d = (state_q == ST_DONE) ? hold_q : dmemload;
         end else begin
            wb_wdat_d = ex_aluout;
         end
         if (ex_halt) begin
            wb_halt_d = 1'b1;
         end
      end else if (w_stall && !ext_stall) begin
         // Downstream keeps flowing while memory stalls: feed it a bubble.
         wb_regWrite_d = 1'b0;
         wb_wsel_d     = '0;
         wb_wdat_d     = '0;
      end
   end

   assign wb_regWrite = wb_regWrite_q;
   assign wb_wsel     = wb_wsel_q;
   assign wb_wdat     = wb_wdat_q;
   assign wb_halt     = wb_halt_q;

   // ------------------------------------------------------------------------
   // Wait-limit watchdog
   // ------------------------------------------------------------------------
   generate
      if (WAIT_LIMIT != 0) begin : g_timeout
         logic [31:0] wait_cnt_q, wait_cnt_d;
         logic [31:0] w_cnt_inc;
         logic        timeout_q,  timeout_d;

         // Saturate so a hung bus never wraps the count back below the limit.
         assign w_cnt_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 32'd1;

         always_comb begin
            wait_cnt_d = '0;
            timeout_d  = timeout_q;
            if (state_q == ST_WAIT) begin
               if (w_cnt_inc >= WAIT_LIMIT) begin
                  timeout_d = 1'b1;
               end
               if (state_d == ST_WAIT) begin
                  wait_cnt_d = w_cnt_inc;
               end
            end
         end

         always_ff @(posedge CLK) begin
            if (!nRST) begin
               wait_cnt_q <= '0;
               timeout_q  <= 1'b0;
            end else begin
               wait_cnt_q <= wait_cnt_d;
               timeout_q  <= timeout_d;
            end
         end

         assign mem_timeout = timeout_q;
      end else begin : g_no_timeout
         assign mem_timeout = 1'b0;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------------
`ifdef MEM_PERF_CNT_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_ops_q,   perf_ops_d;

   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_ops_d   = perf_ops_q;
      if (w_stall) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
      // An ack only counts when a request was actually on the bus.
      if (dhit && w_req && w_active) begin
         perf_ops_d = perf_ops_q + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         perf_stall_q <= '0;
         perf_ops_q   <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_ops_q   <= perf_ops_d;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_mem_ops   = perf_ops_q;
`else
   assign perf_stall_cnt = '0;
   assign perf_mem_ops   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Self-checking bench for mem_wb_stage. Single-cycle instructions
//            come from a vector table; multi-cycle handshakes (wait states,
//            freeze-while-acked, timeout, halt) are hand-written sequences.
//            Expected MEM/WB contents are queued when stimulus is driven and
//            popped after the following rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

   localparam int unsigned WL = 4;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] ex_cpc, ex_aluout, ex_writeData, ex_imm, dmemload;
   logic        ex_regWrite, ex_memtoReg, ex_halt, ex_branch, ex_zflag;
   logic        ex_dren, ex_dwen, ext_stall, dhit;
   logic [1:0]  ex_jump;
   logic [4:0]  ex_wsel;
   logic [25:0] ex_jaddr;
   logic        dmemREN, dmemWEN, mem_stall, pc_redirect;
   logic        wb_regWrite, wb_halt, mem_timeout;
   logic [31:0] dmemaddr, dmemstore, pc_target, wb_wdat;
   logic [31:0] perf_stall_cnt, perf_mem_ops;
   logic [4:0]  wb_wsel;

   always #5 CLK = ~CLK;

   mem_wb_stage #(.WAIT_LIMIT(WL), .JAL_REG(5'd31)) dut (
      .CLK(CLK), .nRST(nRST),
      .ex_cpc(ex_cpc), .ex_regWrite(ex_regWrite), .ex_memtoReg(ex_memtoReg),
      .ex_halt(ex_halt), .ex_branch(ex_branch), .ex_zflag(ex_zflag),
      .ex_dren(ex_dren), .ex_dwen(ex_dwen), .ex_jump(ex_jump),
      .ex_aluout(ex_aluout), .ex_writeData(ex_writeData), .ex_imm(ex_imm),
      .ex_wsel(ex_wsel), .ex_jaddr(ex_jaddr), .ext_stall(ext_stall),
      .dhit(dhit), .dmemload(dmemload),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .mem_stall(mem_stall),
      .pc_redirect(pc_redirect), .pc_target(pc_target),
      .wb_regWrite(wb_regWrite), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
      .wb_halt(wb_halt), .mem_timeout(mem_timeout),
      .perf_stall_cnt(perf_stall_cnt), .perf_mem_ops(perf_mem_ops)
   );

   int checks   = 0;
   int failures = 0;

   // Expected MEM/WB contents; full=0 means only regWrite is meaningful.
   typedef struct {
      logic        rw;
      logic [4:0]  wsel;
      logic [31:0] wdat;
      logic        full;
   } wb_t;

   wb_t sb_q[$];
   wb_t sb_last;

   typedef struct {
      logic [1:0]  jump;
      logic        branch, zflag, rw, m2r, dren, dwen;
      logic [31:0] cpc, alu, wd, imm;
      logic [4:0]  wsel;
      logic [25:0] jaddr;
      logic [31:0] load;
      logic        e_red;
      logic [31:0] e_tgt;
      logic        e_ren, e_wen, e_rw;
      logic [4:0]  e_wsel;
      logic [31:0] e_wdat;
   } vec_t;

   vec_t vt[10];

   function automatic vec_t mk(
      input logic [1:0] jump, input logic branch, input logic zflag,
      input logic rw, input logic m2r, input logic dren, input logic dwen,
      input logic [31:0] cpc, input logic [31:0] alu, input logic [31:0] wd,
      input logic [31:0] imm, input logic [4:0] wsel, input logic [25:0] jaddr,
      input logic [31:0] load, input logic e_red, input logic [31:0] e_tgt,
      input logic e_ren, input logic e_wen, input logic e_rw,
      input logic [4:0] e_wsel, input logic [31:0] e_wdat);
      vec_t v;
      v.jump = jump; v.branch = branch; v.zflag = zflag; v.rw = rw;
      v.m2r = m2r; v.dren = dren; v.dwen = dwen; v.cpc = cpc; v.alu = alu;
      v.wd = wd; v.imm = imm; v.wsel = wsel; v.jaddr = jaddr; v.load = load;
      v.e_red = e_red; v.e_tgt = e_tgt; v.e_ren = e_ren; v.e_wen = e_wen;
      v.e_rw = e_rw; v.e_wsel = e_wsel; v.e_wdat = e_wdat;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ex_cpc = '0; ex_aluout = '0; ex_writeData = '0; ex_imm = '0;
      ex_regWrite = 0; ex_memtoReg = 0; ex_halt = 0; ex_branch = 0;
      ex_zflag = 0; ex_dren = 0; ex_dwen = 0; ex_jump = 2'b00;
      ex_wsel = '0; ex_jaddr = '0; ext_stall = 0; dhit = 0; dmemload = '0;
   endtask

   task automatic push_new(input logic rw, input logic [4:0] wsel, input logic [31:0] wdat);
      wb_t e;
      e.rw = rw; e.wsel = wsel; e.wdat = wdat; e.full = 1'b1;
      sb_q.push_back(e);
      sb_last = e;
   endtask

   task automatic push_bubble();
      wb_t e;
      e.rw = 1'b0; e.wsel = '0; e.wdat = '0; e.full = 1'b0;
      sb_q.push_back(e);
      sb_last = e;
   endtask

   task automatic push_hold();
      sb_q.push_back(sb_last);
   endtask

   // Clock one edge and compare the MEM/WB register with the queue head.
   task automatic tick();
      wb_t e;
      @(posedge CLK);
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_empty actual=0 expected=1");
      end else begin
         e = sb_q.pop_front();
         chk("wb_regWrite", {31'd0, wb_regWrite}, {31'd0, e.rw});
         if (e.full) begin
            chk("wb_wsel", {27'd0, wb_wsel}, {27'd0, e.wsel});
            chk("wb_wdat", wb_wdat, e.wdat);
         end
      end
      @(negedge CLK);
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      idle_inputs();
      @(posedge CLK);
      #1;
      chk("rst_wb_regWrite", {31'd0, wb_regWrite}, 32'd0);
      chk("rst_wb_wsel",     {27'd0, wb_wsel},     32'd0);
      chk("rst_wb_wdat",     wb_wdat,              32'd0);
      chk("rst_wb_halt",     {31'd0, wb_halt},     32'd0);
      chk("rst_mem_timeout", {31'd0, mem_timeout}, 32'd0);
      sb_q.delete();
      sb_last.rw = 0; sb_last.wsel = '0; sb_last.wdat = '0; sb_last.full = 1'b1;
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //           jump  br zf rw m2r rd wr cpc           alu           wd          imm           wsel   jaddr      load          red tgt           ren wen erw ewsel  ewdat
      vt[0] = mk(2'b00, 0, 0, 1, 0, 0, 0, 32'h0,        32'h11112222, 32'h0,      32'h0,        5'd5,  26'h0,     32'h0,        0, 32'h0,        0, 0, 1, 5'd5,  32'h11112222);
      vt[1] = mk(2'b00, 0, 0, 1, 1, 1, 0, 32'h0,        32'h200,      32'h0,      32'h0,        5'd7,  26'h0,     32'hCAFEF00D, 0, 32'h0,        1, 0, 1, 5'd7,  32'hCAFEF00D);
      vt[2] = mk(2'b00, 0, 0, 0, 0, 0, 1, 32'h0,        32'h300,      32'h1234,   32'h0,        5'd0,  26'h0,     32'h0,        0, 32'h0,        0, 1, 0, 5'd0,  32'h300);
      vt[3] = mk(2'b00, 1, 1, 0, 0, 0, 0, 32'h40,       32'h0,        32'h0,      32'hFFFFFFFE, 5'd0,  26'h0,     32'h0,        1, 32'h38,       0, 0, 0, 5'd0,  32'h0);
      vt[4] = mk(2'b00, 1, 0, 0, 0, 0, 0, 32'h40,       32'h0,        32'h0,      32'hFFFFFFFE, 5'd0,  26'h0,     32'h0,        0, 32'h0,        0, 0, 0, 5'd0,  32'h0);
      vt[5] = mk(2'b01, 0, 0, 0, 0, 0, 0, 32'h80000010, 32'h0,        32'h0,      32'h0,        5'd3,  26'h10,    32'h0,        1, 32'h80000040, 0, 0, 0, 5'd3,  32'h0);
      vt[6] = mk(2'b11, 0, 0, 0, 0, 0, 0, 32'h80000010, 32'h0,        32'h0,      32'h0,        5'd3,  26'h10,    32'h0,        1, 32'h80000040, 0, 0, 1, 5'd31, 32'h80000010);
      vt[7] = mk(2'b10, 0, 0, 0, 0, 0, 0, 32'h0,        32'h00400020, 32'h0,      32'h0,        5'd0,  26'h0,     32'h0,        1, 32'h00400020, 0, 0, 0, 5'd0,  32'h00400020);
      vt[8] = mk(2'b00, 0, 0, 0, 0, 1, 1, 32'h0,        32'h404,      32'h77,     32'h0,        5'd0,  26'h0,     32'h0,        0, 32'h0,        0, 1, 0, 5'd0,  32'h404);
      vt[9] = mk(2'b00, 1, 1, 1, 0, 0, 0, 32'h1000,     32'h9,        32'h0,      32'h10,       5'd12, 26'h0,     32'h0,        1, 32'h1040,     0, 0, 1, 5'd12, 32'h9);

      idle_inputs();
      nRST = 1'b0;
      @(negedge CLK);
      do_reset();

      // ---------------- single-cycle vector table ----------------
      for (int i = 0; i < 10; i++) begin
         ex_jump = vt[i].jump; ex_branch = vt[i].branch; ex_zflag = vt[i].zflag;
         ex_regWrite = vt[i].rw; ex_memtoReg = vt[i].m2r;
         ex_dren = vt[i].dren; ex_dwen = vt[i].dwen; ex_cpc = vt[i].cpc;
         ex_aluout = vt[i].alu; ex_writeData = vt[i].wd; ex_imm = vt[i].imm;
         ex_wsel = vt[i].wsel; ex_jaddr = vt[i].jaddr; dmemload = vt[i].load;
         dhit = vt[i].dren | vt[i].dwen; ext_stall = 0; ex_halt = 0;
         #1;
         chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, vt[i].e_red});
         chk("pc_target",   pc_target,            vt[i].e_tgt);
         chk("dmemREN",     {31'd0, dmemREN},     {31'd0, vt[i].e_ren});
         chk("dmemWEN",     {31'd0, dmemWEN},     {31'd0, vt[i].e_wen});
         chk("mem_stall",   {31'd0, mem_stall},   32'd0);
         if (vt[i].dren | vt[i].dwen) begin
            chk("dmemaddr",  dmemaddr,  vt[i].alu);
            chk("dmemstore", dmemstore, vt[i].wd);
         end
         push_new(vt[i].e_rw, vt[i].e_wsel, vt[i].e_wdat);
         tick();
      end

      // ---------------- lw acked on the third cycle ----------------
      idle_inputs();
      ex_dren = 1; ex_memtoReg = 1; ex_regWrite = 1; ex_aluout = 32'h100; ex_wsel = 5'd9;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("lw_wait_ren",   {31'd0, dmemREN},   32'd1);
         chk("lw_wait_stall", {31'd0, mem_stall}, 32'd1);
         chk("lw_wait_redir", {31'd0, pc_redirect}, 32'd0);
         push_bubble();
         tick();
      end
      dhit = 1; dmemload = 32'hDEADBEEF;
      #1;
      chk("lw_ack_ren",   {31'd0, dmemREN},   32'd1);
      chk("lw_ack_stall", {31'd0, mem_stall}, 32'd0);
      push_new(1'b1, 5'd9, 32'hDEADBEEF);
      tick();
      chk("lw_no_timeout", {31'd0, mem_timeout}, 32'd0);

      // ---------------- ack while frozen: DONE holds data ----------------
      idle_inputs();
      ex_dren = 1; ex_memtoReg = 1; ex_regWrite = 1; ex_aluout = 32'h104; ex_wsel = 5'd10;
      dhit = 1; ext_stall = 1; dmemload = 32'hAAAA5555;
      #1;
      chk("frz_ack_ren",   {31'd0, dmemREN},   32'd1);
      chk("frz_ack_stall", {31'd0, mem_stall}, 32'd0);
      push_hold();
      tick();
      dhit = 0; dmemload = 32'hBBBBBBBB;
      #1;
      chk("done_ren",   {31'd0, dmemREN},   32'd0);
      chk("done_stall", {31'd0, mem_stall}, 32'd0);
      push_hold();
      tick();
      ext_stall = 0; dmemload = 32'h12345678;
      #1;
      chk("done_rel_ren", {31'd0, dmemREN}, 32'd0);
      push_new(1'b1, 5'd10, 32'hAAAA5555);
      tick();

      // ---------------- timeout and stall counter ----------------
      do_reset();
      ex_dren = 1; ex_memtoReg = 1; ex_regWrite = 1; ex_aluout = 32'h180; ex_wsel = 5'd11;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("to_stall", {31'd0, mem_stall}, 32'd1);
         push_bubble();
         tick();
         chk("to_flag", {31'd0, mem_timeout}, (k >= 4) ? 32'd1 : 32'd0);
      end
      dhit = 1; dmemload = 32'h5A5A5A5A;
      push_new(1'b1, 5'd11, 32'h5A5A5A5A);
      tick();
      chk("to_sticky", {31'd0, mem_timeout}, 32'd1);
`ifdef MEM_PERF_CNT_EN
      chk("perf_stall_cnt", perf_stall_cnt, 32'd6);
      chk("perf_mem_ops",   perf_mem_ops,   32'd1);
`else
      chk("perf_stall_cnt", perf_stall_cnt, 32'd0);
      chk("perf_mem_ops",   perf_mem_ops,   32'd0);
`endif
      idle_inputs();
      push_new(1'b0, 5'd0, 32'h0);
      tick();
      chk("to_sticky2", {31'd0, mem_timeout}, 32'd1);

      // ---------------- halt then sw ----------------
      idle_inputs();
      ex_halt = 1;
      push_new(1'b0, 5'd0, 32'h0);
      tick();
      chk("halt_set", {31'd0, wb_halt}, 32'd1);
      idle_inputs();
      ex_dwen = 1; dhit = 1; ex_regWrite = 1; ex_jump = 2'b01;
      ex_aluout = 32'h200; ex_writeData = 32'h55; ex_wsel = 5'd4;
      #1;
      chk("halt_wen",   {31'd0, dmemWEN},     32'd0);
      chk("halt_ren",   {31'd0, dmemREN},     32'd0);
      chk("halt_stall", {31'd0, mem_stall},   32'd0);
      chk("halt_redir", {31'd0, pc_redirect}, 32'd0);
      push_bubble();
      tick();
      chk("halt_hold1", {31'd0, wb_halt}, 32'd1);
      idle_inputs();
      push_bubble();
      tick();
      chk("halt_hold2", {31'd0, wb_halt}, 32'd1);
      do_reset();

      // Pipeline writes again after the halt is cleared.
      ex_regWrite = 1; ex_aluout = 32'h0BADF00D; ex_wsel = 5'd6;
      push_new(1'b1, 5'd6, 32'h0BADF00D);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs, performs data-memory loads/stores over the dcache handshake, and resolves branch/jump PC redirects.
- Owns the MEM/WB pipeline register that feeds writeback and the register file.
- Generates the memory-stall request used by the hazard unit to freeze upstream stages.

Parameters:
- WAIT_LIMIT, 0, max consecutive cycles in WAIT before mem_timeout sets; 0 disables the check.
- JAL_REG, 5'd31, destination register forced for jal.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- ex_cpc  in  32  PC+4 of the instruction.
- ex_regWrite, ex_memtoReg, ex_halt, ex_branch, ex_zflag, ex_dren, ex_dwen  in  1 each  control from EX/MEM.
- ex_jump  in  2  00 none, 01 j, 10 jr, 11 jal.
- ex_aluout  in  32  ALU result / memory address / jr target.
- ex_writeData  in  32  store data.
- ex_imm  in  32  sign-extended immediate.
- ex_wsel  in  5  destination register.
- ex_jaddr  in  26  jump field.
- ext_stall  in  1  global freeze from hazard unit (non-memory cause).
- dhit  in  1  dcache ack.
- dmemload  in  32  load data.
- dmemREN, dmemWEN  out  1  memory request.
- dmemaddr  out  32  equals ex_aluout.
- dmemstore  out  32  equals ex_writeData.
- mem_stall  out  1  request pending without ack.
- pc_redirect  out  1  taken branch/jump this cycle.
- pc_target  out  32  redirect target.
- wb_regWrite  out  1  MEM/WB regWrite.
- wb_wsel  out  5  MEM/WB destination.
- wb_wdat  out  32  MEM/WB write data.
- wb_halt  out  1  sticky halt.
- mem_timeout  out  1  sticky timeout flag.
- perf_stall_cnt, perf_mem_ops  out  32 each  see Optional Feature.

Behaviour:
- Reset (nRST=0 at edge): state=IDLE; wb_regWrite=0, wb_wsel=0, wb_wdat=0, wb_halt=0, mem_timeout=0, hold register=0, wait counter=0. Reset mid-WAIT abandons the request; dmemREN/WEN drop the cycle after reset.
- req = (ex_dren|ex_dwen) & !wb_halt. dmemREN=ex_dren&req&state!=DONE; dmemWEN likewise with ex_dwen. If both dren and dwen are set, WEN wins and REN=0.
- FSM:
  - IDLE: if req & !dhit -> WAIT. If req & dhit & ext_stall -> DONE (capture dmemload into hold register). Otherwise stay.
  - WAIT: request held stable. On dhit: go to IDLE if !ext_stall, else DONE (capture).
  - DONE: no request issued; go to IDLE when !ext_stall.
- mem_stall = req & !dhit & state!=DONE (combinational).
- adv = !mem_stall & !ext_stall. MEM/WB loads only on adv; otherwise holds. While mem_stall & !ext_stall, MEM/WB loads a bubble (wb_regWrite=0).
- Write data: jal -> ex_cpc with wsel=JAL_REG; ex_memtoReg -> dmemload, or the hold register if DONE; else ex_aluout. wb_regWrite = ex_regWrite | (jump==11).
- Redirect (only when adv):
  - branch: ex_branch&ex_zflag -> target ex_cpc+(ex_imm<<2), mod 2^32.
  - j/jal: target {ex_cpc[31:28],ex_jaddr,2'b00}.
  - jr: target ex_aluout.
  - Otherwise pc_redirect=0, pc_target=0.
- Halt: ex_halt & adv sets wb_halt on the next edge; it stays set until reset. Once halted, no memory requests, wb_regWrite=0, pc_redirect=0.
- Timeout: the counter increments each WAIT cycle and clears on leaving WAIT. When WAIT_LIMIT≠0 and the count reaches WAIT_LIMIT, mem_timeout=1 (sticky). The FSM keeps waiting.

Optional Feature:
- MEM_PERF_CNT_EN defined:
  - perf_stall_cnt increments every cycle mem_stall=1 (wraps at 2^32).
  - perf_mem_ops increments on each dhit accepted outside DONE.
  - Both reset to 0.
- Undefined: both outputs constant 0; no counter flops.

Test Plan:
- lw, ex_aluout=0x100, dhit after 3 cycles, dmemload=0xDEADBEEF -> dmemREN high for 3 cycles, mem_stall=1 for 2 cycles; then wb_wdat=0xDEADBEEF, wb_wsel=ex_wsel, wb_regWrite=1.
- sw, dhit same cycle, ex_writeData=0x1234 -> dmemWEN=1 one cycle, dmemstore=0x1234, mem_stall=0, wb_regWrite=0.
- lw with dhit while ext_stall=1 for 2 cycles -> state DONE, no re-request. On release, wb_wdat equals the captured data even though dmemload changed.
- beq, zflag=1, cpc=0x40, imm=0xFFFFFFFE -> pc_redirect=1, pc_target=0x38. jal, cpc=0x80000010, jaddr=0x10 -> target 0x80000040, wb_wdat=0x80000010, wb_wsel=31.
- halt followed by sw -> wb_halt=1 next cycle and stays set; sw issues no dmemWEN; nRST low for one edge clears wb_halt.
- WAIT_LIMIT=4, dhit withheld 6 cycles -> mem_timeout=1 after the 4th WAIT cycle and stays set. With MEM_PERF_CNT_EN, perf_stall_cnt=6.
